hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage RISC-V core. Generates stall/flush strobes for the IF/ID, ID/IE, IE/IM pipeline registers and the PC, and the forwarding selects for the execute-stage ALU operands. Sequences a multi-cycle mul/div unit (MDU) in execute with a start/done handshake and timeout. Sits beside the datapath, fed by register indices and control bits from the ID, IE, IM and IW stages.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_fwd_unit.sv | 31 +++
 rtl/hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   hazard_state_e : MDU sequencing FSM state (RUN, BUSY)
//   FWD_*          : execute-stage operand forwarding select encodings
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    BUSY = 1'b1
  } hazard_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from IW result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from IM ALU result

endpackage

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: combinational forwarding select for one IE source operand.
// Ports:
//   i_rs_e        source register index of the operand in IE
//   i_rd_m/_w     destination register indices in IM / IW
//   i_regwrite_m  IM writes the register file
//   i_regwrite_w  IW writes the register file
//   o_fwd         FWD_MEM, FWD_WB or FWD_RF
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_IDX_WIDTH = 5
) (
  input  logic [REG_IDX_WIDTH-1:0] i_rs_e,
  input  logic [REG_IDX_WIDTH-1:0] i_rd_m,
  input  logic [REG_IDX_WIDTH-1:0] i_rd_w,
  input  logic                     i_regwrite_m,
  input  logic                     i_regwrite_w,
  output logic [1:0]               o_fwd
);

  // x0 is never forwarded; IM is younger than IW, so it wins.
  always_comb begin
    o_fwd = FWD_RF;
    if (i_regwrite_m && (i_rd_m != '0) && (i_rd_m == i_rs_e)) begin
      o_fwd = FWD_MEM;
    end else if (i_regwrite_w && (i_rd_w != '0) && (i_rd_w == i_rs_e)) begin
      o_fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage core.
// Generates stall/flush strobes for PC, IF/ID, ID/IE, IE/IM, the IE operand
// forwarding selects, and sequences the multi-cycle MDU (start/done with
// timeout abort and a sticky error flag).
// Ports:
//   clk, rst                 core clock, asynchronous active-low reset
//   i_RS1_D/i_RS2_D          ID source registers
//   i_RS1_E/i_RS2_E/i_Rd_E   IE source/destination registers
//   i_Rd_M/i_Rd_W            IM/IW destination registers
//   i_RegWrite_M/_W          IM/IW register write enables
//   i_Load_E, i_PCSrc_E      IE load, IE taken branch/jump
//   i_MulDiv_E, i_MDU_Done   IE MDU op, MDU result valid pulse
//   o_Stall*/o_Flush*        pipeline hold/clear strobes
//   o_ForwardA_E/B_E         operand selects (00 RF, 01 IW, 10 IM)
//   o_MDU_Start, o_MDU_Err   MDU start pulse, sticky timeout flag
//   o_StallCnt, o_FlushCnt   saturating perf counters
// Optional feature: define HAZARD_PERF_CNT_EN to build the perf counters;
// otherwise both counter outputs are tied to zero.
//
// MDU FSM:
//   state | meaning
//   RUN   | no MDU op in flight; issues start when an MDU op reaches IE
//   BUSY  | waiting for i_MDU_Done; pipeline held, timer running
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_IDX_WIDTH = 5,
  parameter int MDU_TIMEOUT   = 64,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_IDX_WIDTH-1:0] i_RS1_D,
  input  logic [REG_IDX_WIDTH-1:0] i_RS2_D,
  input  logic [REG_IDX_WIDTH-1:0] i_RS1_E,
  input  logic [REG_IDX_WIDTH-1:0] i_RS2_E,
  input  logic [REG_IDX_WIDTH-1:0] i_Rd_E,
  input  logic [REG_IDX_WIDTH-1:0] i_Rd_M,
  input  logic [REG_IDX_WIDTH-1:0] i_Rd_W,
  input  logic                     i_RegWrite_M,
  input  logic                     i_RegWrite_W,
  input  logic                     i_Load_E,
  input  logic                     i_PCSrc_E,
  input  logic                     i_MulDiv_E,
  input  logic                     i_MDU_Done,
  output logic                     o_StallF,
  output logic                     o_StallD,
  output logic                     o_StallE,
  output logic                     o_FlushD,
  output logic                     o_FlushE,
  output logic                     o_FlushM,
  output logic [1:0]               o_ForwardA_E,
  output logic [1:0]               o_ForwardB_E,
  output logic                     o_MDU_Start,
  output logic                     o_MDU_Err,
  output logic [CNT_WIDTH-1:0]     o_StallCnt,
  output logic [CNT_WIDTH-1:0]     o_FlushCnt
);

  localparam int              TMR_W    = $clog2(MDU_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MDU_TIMEOUT - 1);

  hazard_state_e    state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             err_q, err_d;
  logic             mdu_start;
  logic             mdu_stall;
  logic             lw_stall;

  hazard_fwd_unit #(.REG_IDX_WIDTH(REG_IDX_WIDTH)) u_fwd_a (
    .i_rs_e       (i_RS1_E),
    .i_rd_m       (i_Rd_M),
    .i_rd_w       (i_Rd_W),
    .i_regwrite_m (i_RegWrite_M),
    .i_regwrite_w (i_RegWrite_W),
    .o_fwd        (o_ForwardA_E)
  );

  hazard_fwd_unit #(.REG_IDX_WIDTH(REG_IDX_WIDTH)) u_fwd_b (
    .i_rs_e       (i_RS2_E),
    .i_rd_m       (i_Rd_M),
    .i_rd_w       (i_Rd_W),
    .i_regwrite_m (i_RegWrite_M),
    .i_regwrite_w (i_RegWrite_W),
    .o_fwd        (o_ForwardB_E)
  );

  assign lw_stall = i_Load_E && (i_Rd_E != '0) &&
                    ((i_Rd_E == i_RS1_D) || (i_Rd_E == i_RS2_D));

  // A taken branch in IE squashes the MDU op, so no start is issued for it.
  // Done in the start cycle is ignored because the FSM is still in RUN.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    err_d     = err_q;
    mdu_start = 1'b0;
    mdu_stall = 1'b0;
    case (state_q)
      RUN: begin
        if (i_MulDiv_E && !i_PCSrc_E) begin
          mdu_start = 1'b1;
          mdu_stall = 1'b1;
          tmr_d     = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (i_MDU_Done) begin
          state_d = RUN;
        end else if (tmr_q == TMR_LAST) begin
          // Abort: release the op so the pipeline cannot deadlock.
          err_d   = 1'b1;
          state_d = RUN;
        end else begin
          mdu_stall = 1'b1;
          tmr_d     = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      tmr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
    end
  end

  // While the MDU holds IE, IF..IE freeze and a bubble goes into IM.
  always_comb begin
    o_StallF = 1'b0;
    o_StallD = 1'b0;
    o_StallE = 1'b0;
    o_FlushD = 1'b0;
    o_FlushE = 1'b0;
    o_FlushM = 1'b0;
    if (mdu_stall) begin
      o_StallF = 1'b1;
      o_StallD = 1'b1;
      o_StallE = 1'b1;
      o_FlushM = 1'b1;
    end else begin
      o_StallF = lw_stall;
      o_StallD = lw_stall;
      o_FlushD = i_PCSrc_E;
      o_FlushE = lw_stall || i_PCSrc_E;
    end
  end

  assign o_MDU_Start = mdu_start;
  assign o_MDU_Err   = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (o_StallF && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
      if ((o_FlushD || o_FlushE) && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign o_StallCnt = stall_cnt_q;
  assign o_FlushCnt = flush_cnt_q;
`else
  assign o_StallCnt = '0;
  assign o_FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] i_RS1_D, i_RS2_D, i_RS1_E, i_RS2_E, i_Rd_E, i_Rd_M, i_Rd_W;
  logic       i_RegWrite_M, i_RegWrite_W, i_Load_E, i_PCSrc_E, i_MulDiv_E, i_MDU_Done;
  logic       o_StallF, o_StallD, o_StallE, o_FlushD, o_FlushE, o_FlushM;
  logic [1:0] o_ForwardA_E, o_ForwardB_E;
  logic       o_MDU_Start, o_MDU_Err;
  logic [31:0] o_StallCnt, o_FlushCnt;

  int tests_run = 0;
  int tests_failed = 0;

  hazard_ctrl #(.REG_IDX_WIDTH(5), .MDU_TIMEOUT(8), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_RS1_D(i_RS1_D), .i_RS2_D(i_RS2_D), .i_RS1_E(i_RS1_E), .i_RS2_E(i_RS2_E),
    .i_Rd_E(i_Rd_E), .i_Rd_M(i_Rd_M), .i_Rd_W(i_Rd_W),
    .i_RegWrite_M(i_RegWrite_M), .i_RegWrite_W(i_RegWrite_W),
    .i_Load_E(i_Load_E), .i_PCSrc_E(i_PCSrc_E), .i_MulDiv_E(i_MulDiv_E),
    .i_MDU_Done(i_MDU_Done),
    .o_StallF(o_StallF), .o_StallD(o_StallD), .o_StallE(o_StallE),
    .o_FlushD(o_FlushD), .o_FlushE(o_FlushE), .o_FlushM(o_FlushM),
    .o_ForwardA_E(o_ForwardA_E), .o_ForwardB_E(o_ForwardB_E),
    .o_MDU_Start(o_MDU_Start), .o_MDU_Err(o_MDU_Err),
    .o_StallCnt(o_StallCnt), .o_FlushCnt(o_FlushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, rw_m, rw_w, ld, pc, mul;
    int fa, fb, stf, std, ste, fd, fe, fm, st;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // {StallF, StallD, StallE, FlushD, FlushE, FlushM, MDU_Start}
  function automatic logic [6:0] ctl();
    return {o_StallF, o_StallD, o_StallE, o_FlushD, o_FlushE, o_FlushM, o_MDU_Start};
  endfunction

  task automatic idle();
    i_RS1_D = 0; i_RS2_D = 0; i_RS1_E = 0; i_RS2_E = 0; i_Rd_E = 0; i_Rd_M = 0; i_Rd_W = 0;
    i_RegWrite_M = 0; i_RegWrite_W = 0; i_Load_E = 0; i_PCSrc_E = 0;
    i_MulDiv_E = 0; i_MDU_Done = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle();
    @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t vecs[$];

  initial begin
    int stall_cycles;
    bit released;

    //           rs1d rs2d rs1e rs2e rde rdm rdw rwm rww ld pc mul | fa fb stf std ste fd fe fm st
    vecs.push_back('{0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 5, 0, 0, 0, 5, 1, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 3, 9, 0, 9, 9, 0, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 4, 4, 0, 4, 6, 1, 1, 0, 0, 0,   2, 2, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 6, 4, 0, 4, 6, 1, 1, 0, 0, 0,   1, 2, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 3, 0, 0, 3, 3, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{2, 3, 2, 3, 0, 2, 3, 1, 1, 0, 0, 0,   2, 1, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 1, 0, 0, 1, 0, 0});
    vecs.push_back('{7, 2, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 1, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{7, 9, 0, 0, 8, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 1, 0, 1, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 1, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 1, 1, 0, 0});

    rst = 1'b0;
    idle();
    #1;
    chk("reset_ctl", {25'd0, ctl()}, 64'd0);
    chk("reset_err", {63'd0, o_MDU_Err}, 64'd0);
    chk("reset_cnt", {o_StallCnt, o_FlushCnt}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Combinational vector table (FSM stays in RUN throughout).
    foreach (vecs[i]) begin
      logic [12:0] exp_v, act_v;
      @(negedge clk);
      i_RS1_D = 5'(vecs[i].rs1_d); i_RS2_D = 5'(vecs[i].rs2_d);
      i_RS1_E = 5'(vecs[i].rs1_e); i_RS2_E = 5'(vecs[i].rs2_e);
      i_Rd_E = 5'(vecs[i].rd_e); i_Rd_M = 5'(vecs[i].rd_m); i_Rd_W = 5'(vecs[i].rd_w);
      i_RegWrite_M = 1'(vecs[i].rw_m); i_RegWrite_W = 1'(vecs[i].rw_w);
      i_Load_E = 1'(vecs[i].ld); i_PCSrc_E = 1'(vecs[i].pc); i_MulDiv_E = 1'(vecs[i].mul);
      #1;
      exp_v = {2'(vecs[i].fa), 2'(vecs[i].fb), 1'(vecs[i].stf), 1'(vecs[i].std),
               1'(vecs[i].ste), 1'(vecs[i].fd), 1'(vecs[i].fe), 1'(vecs[i].fm), 1'(vecs[i].st)};
      act_v = {o_ForwardA_E, o_ForwardB_E, ctl()};
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL vec%0d: got 0x%0h expected 0x%0h", i, act_v, exp_v);
      end
    end

    // MDU op completing after 5 stall cycles, then a back-to-back op.
    do_reset();
    @(negedge clk); i_MulDiv_E = 1; #1;
    chk("mdu_start_cycle", {57'd0, ctl()}, 64'b1110011);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 2) begin i_Load_E = 1; i_Rd_E = 7; i_RS1_D = 7; end
      else begin i_Load_E = 0; i_Rd_E = 0; i_RS1_D = 0; end
      #1;
      chk($sformatf("mdu_busy%0d", k), {57'd0, ctl()}, 64'b1110010);
    end
    @(negedge clk); i_MDU_Done = 1; #1;
    chk("mdu_done_release", {57'd0, ctl()}, 64'd0);
    @(negedge clk); i_MDU_Done = 1; i_MulDiv_E = 1; #1;
    chk("mdu_b2b_start", {57'd0, ctl()}, 64'b1110011);
    @(negedge clk); i_MDU_Done = 0; #1;
    chk("mdu_done_in_start_ignored", {57'd0, ctl()}, 64'b1110010);
    @(negedge clk); i_MDU_Done = 1; #1;
    chk("mdu_b2b_release", {57'd0, ctl()}, 64'd0);
    @(negedge clk); i_MDU_Done = 0; i_MulDiv_E = 0; #1;
    chk("mdu_idle_after", {57'd0, ctl()}, 64'd0);
    chk("mdu_no_err", {63'd0, o_MDU_Err}, 64'd0);

    // Timeout: no done, MDU_TIMEOUT=8.
    @(negedge clk); i_MulDiv_E = 1; #1;
    chk("tmo_start", {63'd0, o_MDU_Start}, 64'd1);
    stall_cycles = 0;
    released = 0;
    for (int c = 0; c < 20 && !released; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (o_StallE) stall_cycles++;
      else begin
        released = 1;
        chk("tmo_release_ctl", {57'd0, ctl()}, 64'd0);
        chk("tmo_err_not_yet", {63'd0, o_MDU_Err}, 64'd0);
      end
    end
    chk("tmo_released", {63'd0, released}, 64'd1);
    chk("tmo_stall_cycles", 64'(stall_cycles), 64'd8);
    @(negedge clk); i_MulDiv_E = 0; #1;
    chk("tmo_err_set", {63'd0, o_MDU_Err}, 64'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("tmo_err_sticky", {63'd0, o_MDU_Err}, 64'd1);

    // Reset mid-BUSY.
    @(negedge clk); i_MulDiv_E = 1; #1;
    chk("rst2_start", {63'd0, o_MDU_Start}, 64'd1);
    @(negedge clk); #1;
    chk("rst2_busy", {63'd0, o_StallE}, 64'd1);
    #2; rst = 1'b0; i_MulDiv_E = 0; #1;
    chk("rst2_err_clr", {63'd0, o_MDU_Err}, 64'd0);
    chk("rst2_run", {57'd0, ctl()}, 64'd0);
    @(negedge clk); rst = 1'b1; i_MulDiv_E = 1; #1;
    chk("rst2_restart", {57'd0, ctl()}, 64'b1110011);
    @(negedge clk); i_MDU_Done = 1; #1;
    chk("rst2_release", {57'd0, ctl()}, 64'd0);

    // Perf counters: 3 load-use stalls + 2 branch flushes.
    do_reset();
    @(negedge clk); idle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      idle();
      if (k < 3) begin i_Load_E = 1; i_Rd_E = 7; i_RS2_D = 7; end
      else i_PCSrc_E = 1;
    end
    @(negedge clk); idle(); #1;
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_cnt", {32'd0, o_StallCnt}, 64'd3);
    chk("perf_flush_cnt", {32'd0, o_FlushCnt}, 64'd5);
`else
    chk("perf_stall_cnt", {32'd0, o_StallCnt}, 64'd0);
    chk("perf_flush_cnt", {32'd0, o_FlushCnt}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
